// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing toward two
// slaves selected by the address MSB, and an ACCESS-phase timeout that reports an error.
module apb_master_arbiter #(
  parameter int ADDRESS = 8,
  parameter int DATA    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               req0_valid,
  input  logic               req0_write,
  input  logic [ADDRESS-1:0] req0_addr,
  input  logic [DATA-1:0]    req0_wdata,
  output logic               req0_ready,
  output logic               req0_done,
  output logic               req0_err,
  output logic [DATA-1:0]    req0_rdata,
  input  logic               req1_valid,
  input  logic               req1_write,
  input  logic [ADDRESS-1:0] req1_addr,
  input  logic [DATA-1:0]    req1_wdata,
  output logic               req1_ready,
  output logic               req1_done,
  output logic               req1_err,
  output logic [DATA-1:0]    req1_rdata,
  output logic [ADDRESS-1:0] PADDR,
  output logic [DATA-1:0]    PWDATA,
  output logic               PWRITE,
  output logic               PSEL1,
  output logic               PSEL2,
  output logic               PENABLE,
  input  logic [DATA-1:0]    PRDATA1,
  input  logic [DATA-1:0]    PRDATA2,
  input  logic               PREADY1,
  input  logic               PREADY2
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               owner_q, owner_d;
  logic               sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ADDRESS-1:0] paddr_q, paddr_d;
  logic [DATA-1:0]    pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               psel1_q, psel1_d;
  logic               psel2_q, psel2_d;
  logic               penable_q, penable_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [DATA-1:0]    rdata0_q, rdata0_d;
  logic [DATA-1:0]    rdata1_q, rdata1_d;

  logic               in_idle;
  logic               grant0, grant1;
  logic [ADDRESS-1:0] gaddr;
  logic               pready_sel;
  logic [DATA-1:0]    prdata_sel;
  logic [CW-1:0]      cnt_inc;
  logic               finish;
  logic               timed_out;
  logic [DATA-1:0]    fin_rdata;

  // Ready is combinational, so it must be suppressed while reset is being applied.
  assign in_idle = (state_q == ST_IDLE) && !PRESET;
  assign grant0  = in_idle && req0_valid && (!req1_valid || rr_last_q);
  assign grant1  = in_idle && req1_valid && (!req0_valid || !rr_last_q);
  assign gaddr   = grant1 ? req1_addr : req0_addr;

  assign pready_sel = sel_q ? PREADY2 : PREADY1;
  assign prdata_sel = sel_q ? PRDATA2 : PRDATA1;
  assign cnt_inc    = cnt_q + 1'b1;
  assign timed_out  = (state_q == ST_ACCESS) && !pready_sel && (cnt_inc == TO_VAL);
  assign finish     = (state_q == ST_ACCESS) && (pready_sel || timed_out);
  assign fin_rdata  = (pready_sel && !pwrite_q) ? prdata_sel : '0;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = '0;
    rdata1_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          owner_d   = grant1;
          rr_last_d = grant1;
          sel_d     = gaddr[ADDRESS-1];
          paddr_d   = {1'b0, gaddr[ADDRESS-2:0]};
          pwdata_d  = grant1 ? req1_wdata : req0_wdata;
          pwrite_d  = grant1 ? req1_write : req0_write;
          psel1_d   = !gaddr[ADDRESS-1];
          psel2_d   = gaddr[ADDRESS-1];
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          paddr_d   = '0;
          pwdata_d  = '0;
          pwrite_d  = 1'b0;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (finish) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          paddr_d   = '0;
          pwdata_d  = '0;
          pwrite_d  = 1'b0;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          done_d    = owner_q ? 2'b10 : 2'b01;
          err_d     = (owner_q ? 2'b10 : 2'b01) & {2{timed_out}};
          if (owner_q) rdata1_d = fin_rdata;
          else         rdata0_d = fin_rdata;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PWRITE     = pwrite_q;
  assign PSEL1      = psel1_q;
  assign PSEL2      = psel2_q;
  assign PENABLE    = penable_q;

endmodule
